universal_gate_sequencer: RTL and testbench

Multi-cycle logic evaluator that computes NOT/AND/OR/NAND/NOR/XOR/XNOR on two WIDTH-bit operands using a single shared WIDTH-wide primitive gate array, either NAND or NOR. An internal micro-sequencer schedules one primitive evaluation per clock and keeps intermediates in scratch registers. It replaces per-function gate networks wherever the universal-gate function units need sharing or sequencing. Requests and results use a start/busy/done handshake.

---
 rtl/universal_gate_sequencer.sv | 168 ++++++++++++++++
 tb/tb_universal_gate_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/universal_gate_sequencer.sv
// Bitwise logic evaluator that runs every function as a short micro-program on a
// single shared WIDTH-wide NAND/NOR gate array, one primitive evaluation per clock.
module universal_gate_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       nsteps
);
    typedef enum logic {IDLE, RUN} state_t;
    // Program shapes are expressed in terms of the selected primitive, so the
    // NAND and NOR duals share one microcode table.
    typedef enum logic [2:0] {
        P_SELF, P_DIRECT, P_DIRECT_INV, P_DUAL, P_DUAL_INV,
        P_XCHAIN, P_XCHAIN_INV, P_ILLEGAL
    } prog_t;
    typedef enum logic [2:0] {S_A, S_B, S_T0, S_T1, S_T2} src_t;

    state_t           state_reg;
    prog_t            prog_reg, prog_dec;
    logic [2:0]       len_reg, len_dec, step_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] a_reg, b_reg, t0_reg, t1_reg, t2_reg;
    src_t             sel_x, sel_y;
    logic [1:0]       dst;
    logic [WIDTH-1:0] prim_x, prim_y, prim_out;
    logic             last_step;

    always_comb begin
        prog_dec = P_ILLEGAL;
        len_dec  = 3'd1;
        case (op)
            3'b000: begin prog_dec = P_SELF; len_dec = 3'd1; end
            3'b001: begin prog_dec = mode ? P_DUAL : P_DIRECT_INV;        len_dec = mode ? 3'd3 : 3'd2; end
            3'b010: begin prog_dec = mode ? P_DIRECT_INV : P_DUAL;        len_dec = mode ? 3'd2 : 3'd3; end
            3'b011: begin prog_dec = mode ? P_XCHAIN_INV : P_XCHAIN;      len_dec = mode ? 3'd5 : 3'd4; end
            3'b100: begin prog_dec = mode ? P_XCHAIN : P_XCHAIN_INV;      len_dec = mode ? 3'd4 : 3'd5; end
            3'b101: begin prog_dec = mode ? P_DUAL_INV : P_DIRECT;        len_dec = mode ? 3'd4 : 3'd1; end
            3'b110: begin prog_dec = mode ? P_DIRECT : P_DUAL_INV;        len_dec = mode ? 3'd1 : 3'd4; end
            default: begin prog_dec = P_ILLEGAL; len_dec = 3'd1; end
        endcase
    end

    // Microcode: operand selects and destination for the current step.
    // Every "_INV" program ends with t0 = p(t0, t0) after its base program.
    always_comb begin
        sel_x = S_A;
        sel_y = S_A;
        dst   = 2'd0;
        case (prog_reg)
            P_DIRECT: begin sel_x = S_A; sel_y = S_B; end
            P_DIRECT_INV: begin
                if (step_reg == 3'd0) begin sel_x = S_A; sel_y = S_B; end
                else begin sel_x = S_T0; sel_y = S_T0; end
            end
            P_DUAL, P_DUAL_INV: begin
                case (step_reg)
                    3'd0:    begin sel_x = S_A;  sel_y = S_A;  dst = 2'd0; end
                    3'd1:    begin sel_x = S_B;  sel_y = S_B;  dst = 2'd1; end
                    3'd2:    begin sel_x = S_T0; sel_y = S_T1; dst = 2'd0; end
                    default: begin sel_x = S_T0; sel_y = S_T0; dst = 2'd0; end
                endcase
            end
            P_XCHAIN, P_XCHAIN_INV: begin
                case (step_reg)
                    3'd0:    begin sel_x = S_A;  sel_y = S_B;  dst = 2'd0; end
                    3'd1:    begin sel_x = S_A;  sel_y = S_T0; dst = 2'd1; end
                    3'd2:    begin sel_x = S_B;  sel_y = S_T0; dst = 2'd2; end
                    3'd3:    begin sel_x = S_T1; sel_y = S_T2; dst = 2'd0; end
                    default: begin sel_x = S_T0; sel_y = S_T0; dst = 2'd0; end
                endcase
            end
            default: begin sel_x = S_A; sel_y = S_A; dst = 2'd0; end
        endcase
    end

    function automatic logic [WIDTH-1:0] pick(input src_t s, input logic [WIDTH-1:0] va,
                                              input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] v0,
                                              input logic [WIDTH-1:0] v1, input logic [WIDTH-1:0] v2);
        case (s)
            S_A:     return va;
            S_B:     return vb;
            S_T0:    return v0;
            S_T1:    return v1;
            default: return v2;
        endcase
    endfunction

    assign prim_x    = pick(sel_x, a_reg, b_reg, t0_reg, t1_reg, t2_reg);
    assign prim_y    = pick(sel_y, a_reg, b_reg, t0_reg, t1_reg, t2_reg);
    assign last_step = (step_reg == len_reg - 3'd1);

    // The one shared primitive gate array.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prim
        assign prim_out[gi] = mode_reg ? ~(prim_x[gi] | prim_y[gi]) : ~(prim_x[gi] & prim_y[gi]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            prog_reg  <= P_ILLEGAL;
            len_reg   <= 3'd1;
            step_reg  <= 3'd0;
            mode_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            t0_reg    <= '0;
            t1_reg    <= '0;
            t2_reg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            y         <= '0;
            nsteps    <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        mode_reg  <= mode;
                        prog_reg  <= prog_dec;
                        len_reg   <= len_dec;
                        step_reg  <= 3'd0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    if (prog_reg == P_ILLEGAL) begin
                        y         <= '0;
                        err       <= 1'b1;
                        nsteps    <= 3'd0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        case (dst)
                            2'd0:    t0_reg <= prim_out;
                            2'd1:    t1_reg <= prim_out;
                            default: t2_reg <= prim_out;
                        endcase
                        step_reg <= step_reg + 3'd1;
                        // Every program finishes by writing t0, so y takes the same value.
                        if (last_step) begin
                            y         <= prim_out;
                            nsteps    <= len_reg;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_universal_gate_sequencer.sv
// Bench for universal_gate_sequencer: directed vector table, random ops against a
// functional model, and hand-written handshake/reset sequences.
module tb_universal_gate_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       mode = 1'b0;
    logic [3:0] a = 4'd0, b = 4'd0;
    logic       busy, done, err;
    logic [3:0] y;
    logic [2:0] nsteps;

    int n_checks = 0;
    int n_fail = 0;

    universal_gate_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .mode(mode),
        .a(a), .b(b), .busy(busy), .done(done), .err(err), .y(y), .nsteps(nsteps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       mode;
        logic [3:0] a, b, ey;
        logic [2:0] en;
        logic       ee;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Functional model: result from the boolean meaning of op.
    function automatic logic [3:0] ref_y(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb);
        case (o)
            3'd0: return ~va;
            3'd1: return va & vb;
            3'd2: return va | vb;
            3'd3: return va ^ vb;
            3'd4: return ~(va ^ vb);
            3'd5: return ~(va & vb);
            3'd6: return ~(va | vb);
            default: return 4'd0;
        endcase
    endfunction

    // Step count: NAND-world cost of the function; in NOR mode the cost of its dual.
    function automatic logic [2:0] ref_n(input logic [2:0] o, input logic m);
        logic [2:0] f;
        f = o;
        if (m) begin
            case (o)
                3'd1: f = 3'd2;
                3'd2: f = 3'd1;
                3'd3: f = 3'd4;
                3'd4: f = 3'd3;
                3'd5: f = 3'd6;
                3'd6: f = 3'd5;
                default: f = o;
            endcase
        end
        case (f)
            3'd0: return 3'd1;
            3'd1: return 3'd2;
            3'd2: return 3'd3;
            3'd3: return 3'd4;
            3'd4: return 3'd5;
            3'd5: return 3'd1;
            3'd6: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic m, input logic [3:0] ai, input logic [3:0] bi,
                         input logic [3:0] ey, input logic [2:0] en, input logic ee, input string tag);
        int cycles;
        int lat;
        lat = ee ? 1 : int'(en);
        @(negedge clk);
        start = 1'b1; op = o; mode = m; a = ai; b = bi;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, busy, 1);
        check({tag, " err_cleared"}, err, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 16) begin
            @(posedge clk); #1;
            cycles++;
        end
        $display("%s: op=%0d mode=%0d a=%b b=%b -> y=%b nsteps=%0d err=%0d latency=%0d",
                 tag, o, m, ai, bi, y, nsteps, err, cycles);
        check({tag, " latency"}, cycles, lat);
        check({tag, " y"}, y, ey);
        check({tag, " nsteps"}, nsteps, en);
        check({tag, " err"}, err, ee);
        check({tag, " busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, done_at, busy_low;
        int done_pos[$];
        logic [2:0] ro;
        logic rm;
        logic [3:0] ra, rb;

        vecs[0]  = '{3'd0, 1'b0, 4'hC, 4'hA, 4'b0011, 3'd1, 1'b0};
        vecs[1]  = '{3'd1, 1'b0, 4'hC, 4'hA, 4'b1000, 3'd2, 1'b0};
        vecs[2]  = '{3'd2, 1'b0, 4'hC, 4'hA, 4'b1110, 3'd3, 1'b0};
        vecs[3]  = '{3'd3, 1'b0, 4'hC, 4'hA, 4'b0110, 3'd4, 1'b0};
        vecs[4]  = '{3'd4, 1'b0, 4'hC, 4'hA, 4'b1001, 3'd5, 1'b0};
        vecs[5]  = '{3'd5, 1'b0, 4'hC, 4'hA, 4'b0111, 3'd1, 1'b0};
        vecs[6]  = '{3'd6, 1'b0, 4'hC, 4'hA, 4'b0001, 3'd4, 1'b0};
        vecs[7]  = '{3'd0, 1'b1, 4'hC, 4'hA, 4'b0011, 3'd1, 1'b0};
        vecs[8]  = '{3'd1, 1'b1, 4'hC, 4'hA, 4'b1000, 3'd3, 1'b0};
        vecs[9]  = '{3'd2, 1'b1, 4'hC, 4'hA, 4'b1110, 3'd2, 1'b0};
        vecs[10] = '{3'd3, 1'b1, 4'hC, 4'hA, 4'b0110, 3'd5, 1'b0};
        vecs[11] = '{3'd4, 1'b1, 4'hC, 4'hA, 4'b1001, 3'd4, 1'b0};
        vecs[12] = '{3'd5, 1'b1, 4'hC, 4'hA, 4'b0111, 3'd4, 1'b0};
        vecs[13] = '{3'd6, 1'b1, 4'hC, 4'hA, 4'b0001, 3'd1, 1'b0};
        vecs[14] = '{3'd7, 1'b0, 4'hC, 4'hA, 4'b0000, 3'd0, 1'b1};
        vecs[15] = '{3'd1, 1'b0, 4'hF, 4'h5, 4'b0101, 3'd2, 1'b0};

        // Reset state
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset y", y, 0);
        check("reset nsteps", nsteps, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++)
            do_op(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b,
                  vecs[i].ey, vecs[i].en, vecs[i].ee, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rm = 1'($urandom_range(0, 1));
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_op(ro, rm, ra, rb, ref_y(ro, ra, rb), ref_n(ro, rm), (ro == 3'd7),
                  $sformatf("rand%0d", i));
        end

        // Input and start activity during RUN must not disturb an XOR in flight.
        @(negedge clk);
        start = 1'b1; op = 3'd3; mode = 1'b0; a = 4'hC; b = 4'hA;
        @(posedge clk); #1;
        dones = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            case (k)
                1: begin start = 1'b1; a = 4'hF; mode = 1'b1; end
                2: begin start = 1'b0; b = 4'h0; end
                3: begin start = 1'b1; op = 3'd0; end
                default: start = 1'b0;
            endcase
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                done_at = k;
                check("toggle y", y, 4'b0110);
                check("toggle nsteps", nsteps, 3'd4);
            end
        end
        $display("toggle: dones=%0d done_at=%0d y=%b busy=%0d", dones, done_at, y, busy);
        check("toggle done_count", dones, 1);
        check("toggle done_cycle", done_at, 4);
        check("toggle no_reaccept", busy, 0);

        // start held high: back-to-back XNOR every N+1 = 6 cycles.
        @(negedge clk);
        start = 1'b1; op = 3'd4; mode = 1'b0; a = 4'hC; b = 4'hA;
        @(posedge clk); #1;
        busy_low = 0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_pos.push_back(k);
                check("b2b y", y, 4'b1001);
            end
            if (busy === 1'b0) busy_low++;
        end
        start = 1'b0;
        $display("b2b: dones=%0d busy_low_cycles=%0d", done_pos.size(), busy_low);
        check("b2b done_count", done_pos.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b done%0d_cycle", i), (done_pos.size() > i) ? done_pos[i] : -1, 6 * i + 5);
        check("b2b busy_low", busy_low, 3);
        repeat (3) @(posedge clk);
        #1 check("b2b stopped", busy, 0);

        // Asynchronous reset mid-program discards the op.
        @(negedge clk);
        start = 1'b1; op = 3'd4; mode = 1'b0; a = 4'hC; b = 4'hA;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst y", y, 0);
        check("rst done", done, 0);
        check("rst nsteps", nsteps, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        $display("reset mid-op: dones_after=%0d busy=%0d y=%b", dones, busy, y);
        check("rst no_done", dones, 0);
        check("rst idle", busy, 0);
        do_op(3'd2, 1'b0, 4'hC, 4'hA, 4'b1110, 3'd3, 1'b0, "post_reset_or");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
